// File: rtl/pipelined_alu_hs.sv
// Parametrised pipelined ALU with valid/ready handshakes, tag sideband and status flags.
// Stage 1 computes; later stages only register. Per-stage advance lets bubbles collapse under a stall.
module pipelined_alu_hs #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      done_count
);

    localparam int SH_W = $clog2(WIDTH);

    // Returns {C, V, N, Z, result}.
    function automatic logic [WIDTH+3:0] alu_eval(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [2:0]       op);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic             big_sh;
        wide   = '0;
        r      = '0;
        c      = 1'b0;
        v      = 1'b0;
        big_sh = |b[WIDTH-1:SH_W];
        case (op)
            3'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
                wide = {1'b0, a} - {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = big_sh ? '0 : (a << b[SH_W-1:0]);
            3'd6: r = big_sh ? '0 : (a >> b[SH_W-1:0]);
            default: r = {{(WIDTH-1){1'b0}}, (a < b)};
        endcase
        return {c, v, r[WIDTH-1], ~|r, r};
    endfunction

    logic [STAGES-1:0] vld_q, vld_d, take, load;
    logic [WIDTH-1:0]  s1_res;
    logic [3:0]        s1_flg;

    logic [WIDTH-1:0]  res_q [STAGES-1];
    logic [3:0]        flg_q [STAGES-1];
    logic [TAG_W-1:0]  tag_q [STAGES-1];

    logic [WIDTH-1:0]  result_q;
    logic [3:0]        flags_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic [15:0]       done_q;

    assign {s1_flg, s1_res} = alu_eval(A, B, opcode);

    // take[i]: stage i is empty or hands its op on this cycle, so it may load.
    always_comb begin : adv_comb
        logic t;
        t    = !vld_q[STAGES-1] || out_ready;
        take = '0;
        load = '0;
        take[STAGES-1] = t;
        for (int i = STAGES - 2; i >= 0; i--) begin
            t       = !vld_q[i] || t;
            take[i] = t;
        end
        load[0] = in_valid && take[0];
        for (int i = 1; i < STAGES; i++) begin
            load[i] = vld_q[i-1] && take[i];
        end
        vld_d = (vld_q & ~take) | load;
    end

    assign in_ready = take[0];

    // ---- stages 1 .. STAGES-1: data only, no reset ----
    always_ff @(posedge clk) begin
        if (load[0]) begin
            res_q[0] <= s1_res;
            flg_q[0] <= s1_flg;
            tag_q[0] <= in_tag;
        end
        for (int i = 1; i < STAGES - 1; i++) begin
            if (load[i]) begin
                res_q[i] <= res_q[i-1];
                flg_q[i] <= flg_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // ---- stage STAGES: drives the outputs directly ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            out_tag_q <= '0;
            done_q    <= '0;
        end else begin
            vld_q <= vld_d;
            if (load[STAGES-1]) begin
                result_q  <= res_q[STAGES-2];
                flags_q   <= flg_q[STAGES-2];
                out_tag_q <= tag_q[STAGES-2];
            end
            if (vld_q[STAGES-1] && out_ready) begin
                done_q <= done_q + 16'd1;
            end
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign result     = result_q;
    assign flags      = flags_q;
    assign out_tag    = out_tag_q;
    assign done_count = done_q;

endmodule

// File: tb/tb_pipelined_alu_hs.sv
// Self-checking bench for pipelined_alu_hs: directed vector table, stall/reset sequences,
// and a scoreboard fed from an integer-arithmetic reference model.
module tb_pipelined_alu_hs;

    localparam int WIDTH  = 8;
    localparam int STAGES = 3;
    localparam int TAG_W  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      done_count;

    always #5 clk = ~clk;

    pipelined_alu_hs #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags), .out_tag(out_tag), .done_count(done_count)
    );

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flg;
        logic [3:0] tag;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] tag;
        logic [7:0] res;
        logic [3:0] flg;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    int   xfer_cnt = 0;
    int   exp_done = 0;
    exp_t sb_q[$];
    int   log_tag[$];
    int   log_cyc[$];
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {C,V,N,Z,result}.
    function automatic logic [11:0] ref_op(input int a, input int b, input int op);
        int   r, s, sa, sb;
        logic c, v;
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        s  = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0: begin r = (a + b) % 256; c = (a + b) > 255; s = sa + sb; v = (s > 127) || (s < -128); end
            1: begin r = (a - b + 256) % 256; c = a < b; s = sa - sb; v = (s > 127) || (s < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (b >= 8) ? 0 : ((a << b) % 256);
            6: r = (b >= 8) ? 0 : (a >> b);
            default: r = (a < b) ? 1 : 0;
        endcase
        return {c, v, (r >= 128), (r == 0), r[7:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: records accepts, checks every output transfer in order.
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
            exp_done = 0;
        end else begin
            if (out_valid && out_ready) begin
                exp_t e;
                check("done_count_track", 32'(done_count), 32'(exp_done));
                check("output_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_result", 32'(result), 32'(e.res));
                    check("sb_flags", 32'(flags), 32'(e.flg));
                    check("sb_tag", 32'(out_tag), 32'(e.tag));
                end
                exp_done = (exp_done + 1) % 65536;
                xfer_cnt++;
                log_tag.push_back(int'(out_tag));
                log_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                logic [11:0] m;
                m = ref_op(int'(A), int'(B), int'(opcode));
                sb_q.push_back({m[7:0], m[11:8], in_tag});
                acc_cnt++;
            end
        end
    end

    task automatic drive_rand();
        opcode = 3'($urandom_range(0, 7));
        A      = 8'($urandom_range(0, 255));
        B      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        in_tag = 4'($urandom_range(0, 15));
    endtask

    // Asserts reset mid-cycle, checks outputs clear with no clock edge, releases away from the edge.
    task automatic do_reset(input string pfx);
        @(posedge clk);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        check({pfx, "_done_count"}, 32'(done_count), 32'd0);
        check({pfx, "_result"}, 32'(result), 32'd0);
        check({pfx, "_flags"}, 32'(flags), 32'd0);
        check({pfx, "_out_tag"}, 32'(out_tag), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        lat = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        opcode    = v.op;
        A         = v.a;
        B         = v.b;
        in_tag    = v.tag;
        @(negedge clk);
        check($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = c;
        end
        check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(STAGES - 1));
        check($sformatf("vec%0d_result", idx), 32'(result), 32'(v.res));
        check($sformatf("vec%0d_flags", idx), 32'(flags), 32'(v.flg));
        check($sformatf("vec%0d_tag", idx), 32'(out_tag), 32'(v.tag));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   a0, x0, issued;
        logic tog;
        logic [7:0] r_hold;
        logic [3:0] f_hold, t_hold;

        vecs[0]  = '{3'd0, 8'd10,   8'd5,   4'd1,  8'd15,  4'b0000};
        vecs[1]  = '{3'd0, 8'd200,  8'd100, 4'd2,  8'd44,  4'b1000};
        vecs[2]  = '{3'd1, 8'd5,    8'd6,   4'd3,  8'd255, 4'b1010};
        vecs[3]  = '{3'd0, 8'd100,  8'd100, 4'd4,  8'd200, 4'b0110};
        vecs[4]  = '{3'd1, 8'd7,    8'd7,   4'd5,  8'd0,   4'b0001};
        vecs[5]  = '{3'd5, 8'd1,    8'd9,   4'd0,  8'd0,   4'b0001};
        vecs[6]  = '{3'd6, 8'h80,   8'd3,   4'd1,  8'h10,  4'b0000};
        vecs[7]  = '{3'd7, 8'd3,    8'd7,   4'd2,  8'd1,   4'b0000};
        vecs[8]  = '{3'd4, 8'hF0,   8'hFF,  4'd3,  8'h0F,  4'b0000};
        vecs[9]  = '{3'd2, 8'hF0,   8'h3C,  4'd6,  8'h30,  4'b0000};
        vecs[10] = '{3'd3, 8'h80,   8'h01,  4'd7,  8'h81,  4'b0010};
        vecs[11] = '{3'd5, 8'h81,   8'd1,   4'd8,  8'h02,  4'b0000};
        vecs[12] = '{3'd1, 8'h80,   8'h01,  4'd9,  8'h7F,  4'b0100};
        vecs[13] = '{3'd7, 8'd7,    8'd3,   4'd10, 8'd0,   4'b0001};
        vecs[14] = '{3'd6, 8'hFF,   8'd8,   4'd11, 8'd0,   4'b0001};
        vecs[15] = '{3'd0, 8'hFF,   8'h01,  4'd12, 8'd0,   4'b1001};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 3'd0;
        A         = '0;
        B         = '0;
        in_tag    = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_done_count", 32'(done_count), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;

        // Directed vectors, one at a time.
        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);
        @(posedge clk);
        #1;

        // Back-to-back issue: four results on consecutive cycles, tags 0..3.
        log_tag.delete();
        log_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            opcode   = vecs[5+i].op;
            A        = vecs[5+i].a;
            B        = vecs[5+i].b;
            in_tag   = vecs[5+i].tag;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("b2b_count", 32'(log_tag.size()), 32'd4);
        if (log_tag.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("b2b_tag%0d", i), 32'(log_tag[i]), 32'(i));
                check($sformatf("b2b_cycle%0d", i), 32'(log_cyc[i] - log_cyc[0]), 32'(i));
            end
        end

        // Stall: exactly STAGES accepts, outputs stable, then drain and resume at full rate.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a0 = acc_cnt;
        for (int c = 0; c < 8; c++) begin
            drive_rand();
            @(posedge clk);
            #1;
        end
        check("stall_accepts", 32'(acc_cnt - a0), 32'(STAGES));
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        r_hold = result;
        f_hold = flags;
        t_hold = out_tag;
        repeat (3) begin
            @(posedge clk);
            #1;
            drive_rand();
        end
        @(negedge clk);
        check("stall_result_stable", 32'(result), 32'(r_hold));
        check("stall_flags_stable", 32'(flags), 32'(f_hold));
        check("stall_tag_stable", 32'(out_tag), 32'(t_hold));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        a0 = acc_cnt;
        x0 = xfer_cnt;
        @(negedge clk);
        check("full_accept_and_drain", 32'(in_ready), 32'd1);
        repeat (6) begin
            @(posedge clk);
            #1;
            drive_rand();
        end
        check("resume_accepts", 32'(acc_cnt - a0), 32'd6);
        check("resume_transfers", 32'(xfer_cnt - x0), 32'd6);
        in_valid = 1'b0;
        repeat (STAGES + 2) @(posedge clk);
        #1;

        // Random ops with out_ready toggling every cycle, from a fresh done_count.
        do_reset("rst2");
        x0     = xfer_cnt;
        issued = 0;
        tog    = 1'b0;
        for (int c = 0; c < 300 && (xfer_cnt - x0) < 20; c++) begin
            @(posedge clk);
            #1;
            out_ready = tog;
            tog       = !tog;
            in_valid  = (issued < 20);
            drive_rand();
            @(negedge clk);
            #1;
            if (in_valid && in_ready) issued++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("toggle_transfers", 32'(xfer_cnt - x0), 32'd20);
        check("toggle_done_count", 32'(done_count), 32'd20);
        check("toggle_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset with ops in flight: nothing stale may appear afterwards.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            drive_rand();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("inflight_out_valid", 32'(out_valid), 32'd1);
        check("inflight_done_count", 32'(done_count), 32'd20);
        do_reset("rst3");
        out_ready = 1'b1;
        x0 = xfer_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("no_stale_transfers", 32'(xfer_cnt - x0), 32'd0);
        check("no_stale_out_valid", 32'(out_valid), 32'd0);
        check("post_reset_done_count", 32'(done_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
